// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to unsigned binary converter, one digit per clock (acc = acc*10 + digit).
// Valid/ready handshake on both sides; flags bad digit nibbles and results above MAX_VALUE.
module bcd_to_binary_seq #(
    parameter int DIGITS    = 5,
    parameter int OUT_W     = 16,
    parameter int MAX_VALUE = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      bin_out,
    output logic                  err_digit,
    output logic                  err_range
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CMP_W-1:0] MAX_EXT  = CMP_W'(MAX_VALUE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_to_binary_seq: DIGITS must be in 1..8");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic               bad;

    logic [3:0]         digit;
    logic [ACC_W-1:0]   acc_x10;
    logic [ACC_W-1:0]   acc_next;
    logic [CMP_W-1:0]   acc_ext;
    logic               bad_next;
    logic               last_digit;
    logic               over_range;

    // Handshake outputs are pure state decodes, so they can never both be high.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Digit datapath: the accumulator is 4*DIGITS bits wide, which always holds
    // 10**DIGITS - 1, so the truncated multiply-by-ten never loses information.
    always_comb begin
        digit      = shreg[ACC_W-1 -: 4];
        acc_x10    = (acc << 3) + (acc << 1);
        acc_next   = acc_x10 + ACC_W'(digit);
        acc_ext    = CMP_W'(acc_next);
        bad_next   = bad | (digit > 4'd9);
        last_digit = (cnt == '0);
        over_range = (acc_ext > MAX_EXT);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid)   state_next = S_CONV;
            S_CONV: if (last_digit) state_next = S_DONE;
            S_DONE: if (out_ready)  state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            shreg     <= '0;
            cnt       <= '0;
            bad       <= 1'b0;
            bin_out   <= '0;
            err_digit <= 1'b0;
            err_range <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg     <= bcd_in;
                        acc       <= '0;
                        cnt       <= CNT_LAST;
                        bad       <= 1'b0;
                        err_digit <= 1'b0;
                        err_range <= 1'b0;
                    end
                end
                S_CONV: begin
                    acc   <= acc_next;
                    shreg <= shreg << 4;
                    cnt   <= cnt - CNT_ONE;
                    bad   <= bad_next;
                    // Result registers are loaded on the final digit so they are
                    // already stable in the first DONE cycle.
                    if (last_digit) begin
                        if (bad_next) begin
                            bin_out   <= '0;
                            err_digit <= 1'b1;
                            err_range <= 1'b0;
                        end else if (over_range) begin
                            bin_out   <= MAX_EXT[OUT_W-1:0];
                            err_digit <= 1'b0;
                            err_range <= 1'b1;
                        end else begin
                            bin_out   <= acc_ext[OUT_W-1:0];
                            err_digit <= 1'b0;
                            err_range <= 1'b0;
                        end
                    end
                end
                default: begin
                    // DONE holds everything until the consumer accepts.
                end
            endcase
        end
    end

endmodule
